// File: rtl/uart_word_loader_pkg.sv
// uart_loader_pkg: shared types and constants for the UART word loader.
//   rx_state_e : receiver FSM states
//   DATA_BITS  : data bits per UART character
//   half_bit() : clocks from start-bit detection to the mid-start-bit sample
// Optional feature macro used by the loader files: UART_PARITY_EN.
package uart_loader_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_word_loader_rx.sv
// uart_rx_byte: UART character receiver (synchroniser, framing FSM, sampling).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   rx         : asynchronous serial input, idle high
//   data       : last assembled byte, valid while byte_stb is high
//   byte_stb   : one-cycle strobe, byte accepted (good stop, good parity)
//   frame_err  : one-cycle strobe, stop bit sampled low
//   parity_err : one-cycle strobe, even-parity mismatch
//   busy       : FSM not in RX_IDLE
// UART_PARITY_EN defined: a parity bit follows the data bits.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 271
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_stb,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  // Two clocks of the half bit are already spent in the synchroniser, so the
  // START decision lands half a bit plus two clocks after the line edge.
  localparam logic [CW-1:0] HALF_LOAD = CW'(half_bit(CLKS_PER_BIT) - 2);

  rx_state_e   state;
  logic        rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      byte_stb   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      byte_stb   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state <= RX_START;
            cnt   <= HALF_LOAD;
          end
        end
        RX_START: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rx_s) state <= RX_IDLE;  // glitch, not a start bit
          else begin
            state   <= RX_DATA;
            cnt     <= BIT_LAST;
            bit_idx <= '0;
            par_bad <= 1'b0;
          end
        end
        RX_DATA: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shreg   <= {rx_s, shreg[7:1]};  // LSB first
            cnt     <= BIT_LAST;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              state <= RX_PARITY;
`else
              state <= RX_STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            cnt   <= BIT_LAST;
            state <= RX_STOP;
            if (rx_s != ^shreg) begin
              par_bad    <= 1'b1;
              parity_err <= 1'b1;
            end
          end
        end
`endif
        RX_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            state <= RX_IDLE;
            if (!rx_s) frame_err <= 1'b1;
            else if (!par_bad) byte_stb <= 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign data = shreg;
  assign busy = (state != RX_IDLE);

endmodule

// File: rtl/uart_word_loader.sv
// uart_word_loader: UART receive front end that packs bytes little-endian
// into words and buffers them in a show-ahead FIFO.
// Ports:
//   CLK, RST    : clock, synchronous active-high reset
//   UART_RX     : serial input, idle high
//   WORD        : FIFO head word (0 when empty)
//   WORD_VALID  : FIFO non-empty
//   WORD_READY  : consumer takes WORD this cycle
//   FRAME_ERR   : one-cycle pulse, stop bit low (partial word cleared)
//   PARITY_ERR  : one-cycle pulse, parity mismatch (0 unless UART_PARITY_EN)
//   OVERFLOW    : one-cycle pulse, completed word dropped on a full FIFO
//   BUSY        : receiver active or partial word held
// Macro UART_PARITY_EN enables even-parity reception.
module uart_word_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 271,
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      UART_RX,
  output logic [8*BYTES_PER_WORD-1:0] WORD,
  output logic                      WORD_VALID,
  input  logic                      WORD_READY,
  output logic                      FRAME_ERR,
  output logic                      PARITY_ERR,
  output logic                      OVERFLOW,
  output logic                      BUSY
);

  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int KW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0] rx_data;
  logic       rx_stb, rx_ferr, rx_perr, rx_busy;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (CLK),
    .rst        (RST),
    .rx         (UART_RX),
    .data       (rx_data),
    .byte_stb   (rx_stb),
    .frame_err  (rx_ferr),
    .parity_err (rx_perr),
    .busy       (rx_busy)
  );

  // Byte packing
  logic [KW-1:0] k;
  logic [W-1:0]  acc, next_word;
  logic          last, push;

  always_comb begin
    next_word = acc;
    next_word[int'(k)*8 +: 8] = rx_data;
  end

  assign last = (k == KW'(BYTES_PER_WORD - 1));
  assign push = rx_stb && last;

  // FIFO
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign pop   = WORD_VALID && WORD_READY;
  // A pop on the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge CLK) begin
    if (RST) begin
      k      <= '0;
      acc    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (rx_ferr || rx_perr) begin
        k   <= '0;
        acc <= '0;
      end else if (rx_stb) begin
        if (last) begin
          k   <= '0;
          acc <= '0;
        end else begin
          k   <= k + 1'b1;
          acc <= next_word;
        end
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (pop && !wr_en) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= next_word;
  end

  assign WORD_VALID = (count != '0);
  assign WORD       = WORD_VALID ? mem[rd_ptr] : '0;
  assign FRAME_ERR  = rx_ferr;
  assign OVERFLOW   = push && full && !pop;
  assign BUSY       = rx_busy || (k != '0);

`ifdef UART_PARITY_EN
  assign PARITY_ERR = rx_perr;
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader (bit time shortened to keep runs short).
module tb_uart_word_loader;

  localparam int CPB = 16;
  localparam int BPW = 4;
  localparam int DEP = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          UART_RX = 1'b1;
  logic          WORD_READY = 1'b1;
  logic [31:0]   WORD;
  logic          WORD_VALID, FRAME_ERR, PARITY_ERR, OVERFLOW, BUSY;

  uart_word_loader #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEP)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .UART_RX    (UART_RX),
    .WORD       (WORD),
    .WORD_VALID (WORD_VALID),
    .WORD_READY (WORD_READY),
    .FRAME_ERR  (FRAME_ERR),
    .PARITY_ERR (PARITY_ERR),
    .OVERFLOW   (OVERFLOW),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Output monitor: cumulative pulse counts and popped words.
  int          vld_cyc = 0, ferr_cyc = 0, perr_cyc = 0, ovf_cyc = 0;
  logic [31:0] popped[$];

  always @(negedge CLK) begin
    if (WORD_VALID) vld_cyc++;
    if (WORD_VALID && WORD_READY) popped.push_back(WORD);
    if (FRAME_ERR)  ferr_cyc++;
    if (PARITY_ERR) perr_cyc++;
    if (OVERFLOW)   ovf_cyc++;
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    UART_RX = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic par_flip);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
`ifdef UART_PARITY_EN
    drive_bit((^b) ^ par_flip, CPB);
`endif
    if (stop_ok) drive_bit(1'b1, CPB);
    else begin
      // Low through the mid-stop sample, then idle long enough for the
      // receiver to reject the tail as a glitch.
      drive_bit(1'b0, CPB/2 + 4);
      drive_bit(1'b1, CPB - (CPB/2 + 4) + CPB);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] ovf_word(input int i);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(i * 16 + j);
    return w;
  endfunction

  int base, f0, p0, o0, v0;

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_word",   WORD, 0);
    check("rst_valid",  WORD_VALID, 0);
    check("rst_ferr",   FRAME_ERR, 0);
    check("rst_perr",   PARITY_ERR, 0);
    check("rst_ovf",    OVERFLOW, 0);
    check("rst_busy",   BUSY, 0);
    RST = 1'b0;
    repeat (2*CPB) @(posedge CLK);
    #1;

    // One word, little-endian packing
    base = popped.size(); f0 = ferr_cyc; p0 = perr_cyc; o0 = ovf_cyc; v0 = vld_cyc;
    send_byte(8'h78, 1'b1, 1'b0);
    send_byte(8'h56, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    send_byte(8'h12, 1'b1, 1'b0);
    repeat (3*CPB) @(posedge CLK);
    #1;
    check("w1_count",  popped.size() - base, 1);
    check("w1_word",   popped[base], 32'h12345678);
    check("w1_vldcyc", vld_cyc - v0, 1);
    check("w1_ferr",   ferr_cyc - f0, 0);
    check("w1_perr",   perr_cyc - p0, 0);
    check("w1_ovf",    ovf_cyc - o0, 0);
    check("w1_busy",   BUSY, 0);

    // Start-bit glitch
    base = popped.size(); f0 = ferr_cyc; p0 = perr_cyc;
    UART_RX = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    UART_RX = 1'b1;
    check("gl_busy_hi", BUSY, 1);
    for (int i = 0; i < 60; i++) begin
      if (!BUSY) break;
      @(posedge CLK);
      #1;
    end
    check("gl_busy_lo", BUSY, 0);
    repeat (2*CPB) @(posedge CLK);
    #1;
    check("gl_nopop",  popped.size() - base, 0);
    check("gl_ferr",   ferr_cyc - f0, 0);
    check("gl_perr",   perr_cyc - p0, 0);

    // Framing error clears the partial word
    base = popped.size(); f0 = ferr_cyc;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'hBB, 1'b1, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    send_word(32'h04030201);
    repeat (3*CPB) @(posedge CLK);
    #1;
    check("fe_pulses", ferr_cyc - f0, 1);
    check("fe_count",  popped.size() - base, 1);
    check("fe_word",   popped[base], 32'h04030201);

    // Overflow on the ninth word, then drain in order
    WORD_READY = 1'b0;
    base = popped.size(); o0 = ovf_cyc;
    for (int i = 0; i < 8; i++) send_word(ovf_word(i));
    repeat (CPB) @(posedge CLK);
    #1;
    check("ov_before", ovf_cyc - o0, 0);
    check("ov_valid",  WORD_VALID, 1);
    check("ov_head",   WORD, 32'h03020100);
    send_word(ovf_word(8));
    repeat (CPB) @(posedge CLK);
    #1;
    check("ov_pulse",  ovf_cyc - o0, 1);
    WORD_READY = 1'b1;
    repeat (16) @(posedge CLK);
    #1;
    check("ov_drained", popped.size() - base, 8);
    for (int i = 0; i < 8; i++) check($sformatf("ov_word%0d", i), popped[base + i], ovf_word(i));
    check("ov_empty",  WORD_VALID, 0);

    // Reset mid-frame with a word already buffered
    WORD_READY = 1'b0;
    send_word(32'hDEADBEEF);
    send_byte(8'h99, 1'b1, 1'b0);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);   // 0xA5: bits 1,0,1,0
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB/2);
    RST = 1'b1;
    UART_RX = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("mr_word",  WORD, 0);
    check("mr_valid", WORD_VALID, 0);
    check("mr_ferr",  FRAME_ERR, 0);
    check("mr_perr",  PARITY_ERR, 0);
    check("mr_ovf",   OVERFLOW, 0);
    check("mr_busy",  BUSY, 0);
    RST = 1'b0;
    WORD_READY = 1'b1;
    repeat (CPB) @(posedge CLK);
    #1;
    base = popped.size();
    send_word(32'h44332211);
    repeat (3*CPB) @(posedge CLK);
    #1;
    check("mr_count", popped.size() - base, 1);
    check("mr_after", popped[base], 32'h44332211);

`ifdef UART_PARITY_EN
    // Bad parity discards the byte, good parity accepts it
    base = popped.size(); p0 = perr_cyc;
    send_byte(8'h03, 1'b1, 1'b1);
    check("pe_pulse", perr_cyc - p0, 1);
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h07, 1'b1, 1'b0);
    repeat (3*CPB) @(posedge CLK);
    #1;
    check("pe_pulses", perr_cyc - p0, 1);
    check("pe_count",  popped.size() - base, 1);
    check("pe_word",   popped[base], 32'h07020103);
`else
    check("np_perr_total", perr_cyc, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
